// File: rtl/panda_risc_v_icb_pkg.sv
// Shared ICB field widths, response error encoding and the response bundle
// carried from the ITCM datapath into its response FIFO.
package panda_risc_v_icb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic ICB_RSP_OK  = 1'b0;
    localparam logic ICB_RSP_ERR = 1'b1;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } icb_rsp_t;

endpackage

// File: rtl/panda_risc_v_itcm_rsp_fifo.sv
// In-order response buffer for the ITCM slave; the head entry is read
// straight out of the storage registers.
module panda_risc_v_itcm_rsp_fifo
    import panda_risc_v_icb_pkg::*;
#(
    parameter int unsigned depth = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  icb_rsp_t din,
    input  logic     pop,
    output icb_rsp_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(depth);

    logic [PW:0] wptr;
    logic [PW:0] rptr;
    icb_rsp_t    mem [depth];

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) &&
                   (wptr[PW-1:0] == rptr[PW-1:0]);
    assign dout  = mem[rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/panda_risc_v_itcm_icb_slave.sv
// ICB responder for the ITCM: decodes commands, drives a 1-cycle-latency
// SRAM and returns in-order responses under a credit-based flow control.
module panda_risc_v_itcm_icb_slave
    import panda_risc_v_icb_pkg::*;
#(
    parameter logic [31:0] itcm_base_addr   = 32'h0000_0000,
    parameter int unsigned itcm_depth       = 8192,
    parameter int unsigned rsp_fifo_depth   = 4,
    parameter int          simulation_delay = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             s_icb_cmd_addr,
    input  logic                          s_icb_cmd_read,
    input  logic [DATA_W-1:0]             s_icb_cmd_wdata,
    input  logic [MASK_W-1:0]             s_icb_cmd_wmask,
    input  logic                          s_icb_cmd_valid,
    output logic                          s_icb_cmd_ready,
    output logic [DATA_W-1:0]             s_icb_rsp_rdata,
    output logic                          s_icb_rsp_err,
    output logic                          s_icb_rsp_valid,
    input  logic                          s_icb_rsp_ready,
    output logic                          sram_en,
    output logic [MASK_W-1:0]             sram_wen,
    output logic [$clog2(itcm_depth)-1:0] sram_addr,
    output logic [DATA_W-1:0]             sram_din,
    input  logic [DATA_W-1:0]             sram_dout
);

    localparam int AW = $clog2(itcm_depth);
    localparam int CW = $clog2(rsp_fifo_depth + 1);
    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(64'(itcm_depth) << 2);

    if (rsp_fifo_depth < 2 || rsp_fifo_depth > 16 ||
        itcm_depth < 16 || itcm_depth > 65536 ||
        simulation_delay < 0) begin : g_bad_param
        $error("panda_risc_v_itcm_icb_slave: illegal parameter");
    end

    logic [CW-1:0]     outstanding;
    logic              cmd_hs;
    logic              rsp_hs;
    logic [ADDR_W-1:0] off;
    logic              range_err;
    logic              align_err;
    logic              err;
    logic              s1_valid;
    logic              s1_err;
    logic              s1_read;
    icb_rsp_t          fifo_din;
    icb_rsp_t          fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    // Credit covers stage 1 plus FIFO, so a push always finds space.
    assign s_icb_cmd_ready = !rst && (outstanding < CW'(rsp_fifo_depth));
    assign s_icb_rsp_valid = !rst && !fifo_empty;
    assign cmd_hs = s_icb_cmd_valid && s_icb_cmd_ready;
    assign rsp_hs = s_icb_rsp_valid && s_icb_rsp_ready;

    assign off       = s_icb_cmd_addr - itcm_base_addr;
    assign range_err = (off >= WIN_BYTES);
    assign align_err = (s_icb_cmd_addr[1:0] != 2'b00);
    assign err       = range_err || align_err;

    assign sram_en   = cmd_hs && !err;
    assign sram_wen  = (sram_en && !s_icb_cmd_read) ? s_icb_cmd_wmask : '0;
    assign sram_addr = off[2 +: AW];
    assign sram_din  = s_icb_cmd_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (cmd_hs && !rsp_hs) begin
            outstanding <= outstanding + 1'b1;
        end else if (!cmd_hs && rsp_hs) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_read  <= 1'b0;
        end else begin
            s1_valid <= cmd_hs;
            s1_err   <= err;
            s1_read  <= s_icb_cmd_read;
        end
    end

    always_comb begin
        fifo_din.err   = s1_err ? ICB_RSP_ERR : ICB_RSP_OK;
        fifo_din.rdata = (s1_read && !s1_err) ? sram_dout : '0;
    end

    panda_risc_v_itcm_rsp_fifo #(
        .depth (rsp_fifo_depth)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .din   (fifo_din),
        .pop   (rsp_hs),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_icb_rsp_rdata = s_icb_rsp_valid ? fifo_dout.rdata : '0;
    assign s_icb_rsp_err   = s_icb_rsp_valid ? fifo_dout.err : ICB_RSP_OK;

endmodule

// File: tb/tb_panda_risc_v_itcm_icb_slave.sv
// Directed and random checks of the ITCM ICB slave against a word-array
// memory model and an expected-response queue.
module tb_panda_risc_v_itcm_icb_slave;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 8192;
    localparam int          FDEP  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_icb_cmd_addr = '0;
    logic        s_icb_cmd_read = 1'b0;
    logic [31:0] s_icb_cmd_wdata = '0;
    logic [3:0]  s_icb_cmd_wmask = '0;
    logic        s_icb_cmd_valid = 1'b0;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready = 1'b0;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [12:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = '0;

    always #5 clk = ~clk;

    panda_risc_v_itcm_icb_slave #(
        .itcm_base_addr   (BASE),
        .itcm_depth       (DEPTH),
        .rsp_fifo_depth   (FDEP),
        .simulation_delay (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_icb_cmd_addr  (s_icb_cmd_addr),
        .s_icb_cmd_read  (s_icb_cmd_read),
        .s_icb_cmd_wdata (s_icb_cmd_wdata),
        .s_icb_cmd_wmask (s_icb_cmd_wmask),
        .s_icb_cmd_valid (s_icb_cmd_valid),
        .s_icb_cmd_ready (s_icb_cmd_ready),
        .s_icb_rsp_rdata (s_icb_rsp_rdata),
        .s_icb_rsp_err   (s_icb_rsp_err),
        .s_icb_rsp_valid (s_icb_rsp_valid),
        .s_icb_rsp_ready (s_icb_rsp_ready),
        .sram_en         (sram_en),
        .sram_wen        (sram_wen),
        .sram_addr       (sram_addr),
        .sram_din        (sram_din),
        .sram_dout       (sram_dout)
    );

    // Physical SRAM the DUT drives: byte writes, 1-cycle read.
    logic [31:0] sram [DEPTH];
    always @(posedge clk) begin
        if (sram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wen[b]) sram[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end
            sram_dout <= sram[sram_addr];
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          t;
    } exp_t;

    logic [31:0] ref_mem [DEPTH];
    exp_t        q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_rsp = 0;
    int          last_rsp_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        acc = 1'b0;
    logic        exact_lat = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: evaluate handshakes mid-cycle, then step past the edge.
    task automatic cycle();
        exp_t        e;
        logic [63:0] a;
        logic        ok;
        int          idx;
        @(negedge clk);
        acc = 1'b0;
        if (rst) begin
            chk("rst_cmd_ready", 64'(s_icb_cmd_ready), 0);
            chk("rst_rsp_valid", 64'(s_icb_rsp_valid), 0);
            chk("rst_sram_en", 64'(sram_en), 0);
            chk("rst_sram_wen", 64'(sram_wen), 0);
            chk("rst_rsp_data", {31'd0, s_icb_rsp_err, s_icb_rsp_rdata}, 0);
            q.delete();
        end else begin
            chk("cmd_ready_credit", 64'(s_icb_cmd_ready), 64'(q.size() < FDEP));
            if (s_icb_rsp_valid && s_icb_rsp_ready) begin
                if (q.size() == 0) begin
                    chk("stale_rsp", 64'(s_icb_rsp_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_err", 64'(s_icb_rsp_err), 64'(e.err));
                    chk("rsp_rdata", 64'(s_icb_rsp_rdata), 64'(e.rdata));
                    if (exact_lat) chk("rsp_latency", 64'(cyc - e.t), 2);
                    else chk("rsp_latency_min", 64'(cyc - e.t >= 2), 1);
                    last_rdata = s_icb_rsp_rdata;
                    last_err = s_icb_rsp_err;
                    last_rsp_cyc = cyc;
                    n_rsp++;
                end
            end
            if (s_icb_cmd_valid && s_icb_cmd_ready) begin
                a = 64'(s_icb_cmd_addr);
                ok = (a >= 64'(BASE)) && (a < 64'(BASE) + 4 * DEPTH) &&
                     (a % 4 == 0);
                idx = int'((a - 64'(BASE)) / 4);
                e.err = !ok;
                e.rdata = '0;
                e.t = cyc;
                chk("sram_en", 64'(sram_en), 64'(ok));
                if (ok) begin
                    chk("sram_addr", 64'(sram_addr), 64'(idx));
                    if (s_icb_cmd_read) begin
                        chk("sram_wen_rd", 64'(sram_wen), 0);
                        e.rdata = ref_mem[idx];
                    end else begin
                        chk("sram_wen_wr", 64'(sram_wen), 64'(s_icb_cmd_wmask));
                        for (int b = 0; b < 4; b++) begin
                            if (s_icb_cmd_wmask[b])
                                ref_mem[idx][8*b +: 8] = s_icb_cmd_wdata[8*b +: 8];
                        end
                    end
                end
                q.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [31:0] a, input logic rd,
                         input logic [31:0] wd, input logic [3:0] wm);
        s_icb_cmd_addr = a;
        s_icb_cmd_read = rd;
        s_icb_cmd_wdata = wd;
        s_icb_cmd_wmask = wm;
        s_icb_cmd_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (acc) break;
        end
        chk("issue_accepted", 64'(acc), 1);
        s_icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        s_icb_rsp_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (q.size() == 0 && !s_icb_rsp_valid) break;
            cycle();
        end
        chk("drain_empty", 64'(q.size()), 0);
        cycle();
        cycle();
    endtask

    int nacc;
    int ndrop;
    int first_hs;
    int n0;
    logic pend;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_cmd_ready", 64'(s_icb_cmd_ready), 1);

        exact_lat = 1'b1;
        issue(32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
        drain();
        s_icb_rsp_ready = 1'b1;
        issue(32'h10, 1'b1, '0, 4'h0);
        drain();
        chk("single_read", {31'd0, last_err, last_rdata}, 64'hDEAD_BEEF);

        issue(32'h20, 1'b0, 32'h1122_3344, 4'hF);
        issue(32'h20, 1'b0, 32'hAAAA_AAAA, 4'b0101);
        issue(32'h24, 1'b0, 32'h5555_5555, 4'b0000);
        issue(32'h20, 1'b1, '0, 4'h0);
        drain();
        chk("byte_mask", 64'(last_rdata), 64'h11AA_33AA);

        issue(32'h22, 1'b1, '0, 4'h0);
        issue(BASE + 4 * DEPTH, 1'b1, '0, 4'h0);
        drain();
        chk("range_err", 64'(last_err), 1);
        issue(BASE + 4 * (DEPTH - 1), 1'b0, 32'hCAFE_F00D, 4'hF);
        issue(BASE + 4 * (DEPTH - 1), 1'b1, '0, 4'h0);
        issue(32'h0, 1'b1, '0, 4'h0);
        drain();
        chk("after_err_read0", {31'd0, last_err, last_rdata}, 0);

        exact_lat = 1'b0;
        s_icb_rsp_ready = 1'b0;
        nacc = 0;
        s_icb_cmd_valid = 1'b1;
        s_icb_cmd_read = 1'b1;
        s_icb_cmd_addr = 32'h20;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (acc) begin
                nacc++;
                s_icb_cmd_addr = s_icb_cmd_addr + 4;
            end
        end
        chk("bp_accepted", 64'(nacc), 4);
        chk("bp_cmd_ready", 64'(s_icb_cmd_ready), 0);
        s_icb_rsp_ready = 1'b1;
        for (int k = 0; k < 30 && nacc < 6; k++) begin
            cycle();
            if (acc) begin
                nacc++;
                s_icb_cmd_addr = s_icb_cmd_addr + 4;
            end
        end
        s_icb_cmd_valid = 1'b0;
        chk("bp_total", 64'(nacc), 6);
        drain();

        for (int i = 0; i < 64; i++) issue(32'h400 + 4 * i, 1'b0, $urandom, 4'hF);
        drain();
        exact_lat = 1'b1;
        s_icb_rsp_ready = 1'b1;
        ndrop = 0;
        first_hs = cyc;
        n0 = n_rsp;
        for (int i = 0; i < 64; i++) begin
            s_icb_cmd_addr = 32'h400 + 4 * i;
            s_icb_cmd_read = 1'b1;
            s_icb_cmd_valid = 1'b1;
            cycle();
            if (!acc) ndrop++;
        end
        s_icb_cmd_valid = 1'b0;
        drain();
        chk("tp_drops", 64'(ndrop), 0);
        chk("tp_nrsp", 64'(n_rsp - n0), 64);
        chk("tp_span", 64'(last_rsp_cyc - first_hs + 1), 66);

        exact_lat = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                case ($urandom_range(0, 9))
                    0: s_icb_cmd_addr = $urandom;
                    1: s_icb_cmd_addr = {17'd0, 13'($urandom), 2'($urandom_range(1, 3))};
                    default: s_icb_cmd_addr = {17'd0, 13'($urandom_range(0, 63)), 2'b00};
                endcase
                s_icb_cmd_read = 1'($urandom);
                s_icb_cmd_wdata = $urandom;
                s_icb_cmd_wmask = 4'($urandom);
                s_icb_cmd_valid = ($urandom_range(0, 3) != 0);
            end
            s_icb_rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            pend = s_icb_cmd_valid && !acc;
        end
        s_icb_cmd_valid = 1'b0;
        drain();

        s_icb_rsp_ready = 1'b0;
        issue(32'h10, 1'b1, '0, 4'h0);
        issue(32'h14, 1'b1, '0, 4'h0);
        issue(32'h20, 1'b1, '0, 4'h0);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(s_icb_rsp_valid), 0);
        chk("midrst_cmd_ready", 64'(s_icb_cmd_ready), 0);
        cycle();
        rst = 1'b0;
        #1;
        chk("postrst_rsp_valid", 64'(s_icb_rsp_valid), 0);
        exact_lat = 1'b1;
        s_icb_rsp_ready = 1'b1;
        issue(32'h10, 1'b1, '0, 4'h0);
        drain();
        chk("postrst_read", 64'(last_rdata), 64'(ref_mem[4]));
        for (int k = 0; k < 4; k++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/panda_risc_v_itcm_icb_slave.md
Name: panda_risc_v_itcm_icb_slave

Overview:
- ICB slave (responder) for the instruction/data tightly-coupled memory (ITCM). It sits at the far end of the instruction ICB that the fetch unit drives as master.
- Accepts ICB commands and drives a single-port synchronous SRAM with 1-cycle read latency.
- Returns in-order responses through a small response FIFO, with error responses for out-of-range or misaligned addresses.
- Sustains one command per cycle when the master keeps rsp_ready high.

Parameters:
- itcm_base_addr, 32'h0000_0000: byte base address of the ITCM window.
- itcm_depth, 8192: ITCM size in 32-bit words (power of 2, 16..65536).
- rsp_fifo_depth, 4: response FIFO entries. Legal range 2..16, power of 2. A value of 3 or more is required for back-to-back throughput.
- simulation_delay, 1: register assignment delay, for simulation only.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_icb_cmd_addr  in  32  byte address
- s_icb_cmd_read  in  1  1 = read, 0 = write
- s_icb_cmd_wdata  in  32  write data
- s_icb_cmd_wmask  in  4  byte write enables
- s_icb_cmd_valid  in  1  command valid
- s_icb_cmd_ready  out  1  command ready
- s_icb_rsp_rdata  out  32  read data
- s_icb_rsp_err  out  1  error flag
- s_icb_rsp_valid  out  1  response valid
- s_icb_rsp_ready  in  1  response ready
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enable
- sram_addr  out  log2(itcm_depth)  SRAM word address
- sram_din  out  32  SRAM write data
- sram_dout  in  32  SRAM read data, valid 1 cycle after sram_en

Behaviour:
- Reset values:
  - While rst = 1: s_icb_cmd_ready = 0, s_icb_rsp_valid = 0, sram_en = 0, sram_wen = 0.
  - Registers cleared: outstanding counter, stage-1 valid, FIFO pointers.
  - s_icb_rsp_rdata and s_icb_rsp_err = 0.
- Reset mid-operation: all in-flight and buffered responses are discarded. The bench must not expect them after rst.
- Outstanding counter (0..rsp_fifo_depth):
  - Increments on a cmd handshake and decrements on a rsp handshake. A simultaneous handshake on both leaves it unchanged.
  - s_icb_cmd_ready = (outstanding < rsp_fifo_depth). This is registered-state only; there is no combinational path from s_icb_rsp_ready.
- Decode at the cmd handshake:
  - off = addr - itcm_base_addr.
  - range_err = off[31:2] >= itcm_depth.
  - align_err = addr[1:0] != 0.
  - err = range_err | align_err.
- SRAM drive, combinational on the handshake cycle T:
  - sram_en = cmd_valid & cmd_ready & ~err.
  - sram_wen = read ? 4'b0000 : wmask, and forced to 0 when err = 1.
  - sram_addr = off[2 +: log2(itcm_depth)].
  - sram_din = wdata.
  - An erroring command never touches the SRAM.
- Stage 1 (cycle T+1): registers valid, err and read. The entry written to the FIFO is:
  - rdata = (read & ~err) ? sram_dout : 0.
  - err as decoded.
  - Entries are pushed unconditionally; the credit scheme guarantees there is space.
- Response:
  - s_icb_rsp_valid = FIFO non-empty, driven from registered FIFO outputs.
  - Minimum latency: rsp_valid at cycle T+2 after the cmd handshake at T.
  - Responses are strictly in command order, errors included.
- Write response: rdata = 0, err = 0 if in range. A wmask of 0 is legal and performs no write.
- Boundary conditions:
  - FIFO full with rsp_ready = 0: cmd_ready stays 0 until a response is popped.
  - Pointers wrap modulo rsp_fifo_depth.
  - Push and pop in the same cycle when full: impossible by credit. If it occurs anyway, it is an assertion failure.
  - Address at the last word (base + 4*(itcm_depth-1)) is legal; the next word returns err = 1.
- Throughput: with rsp_ready held at 1 and rsp_fifo_depth ≥ 3, one command is accepted per cycle indefinitely.

Decomposition:
- The shared package panda_risc_v_icb_pkg holds:
  - ICB field widths (ADDR_W = 32, DATA_W = 32, MASK_W = 4).
  - The response error encoding constant ICB_RSP_OK / ICB_RSP_ERR.
- Sub-module: panda_risc_v_itcm_rsp_fifo.
  - Synchronous FIFO of 33 bits (err + rdata) with registered outputs.
  - Parameterised depth; ports push, pop, full, empty.

Test Plan:
- Reset then single read: write 32'hDEAD_BEEF to 0x10 (wmask 4'hF), then read 0x10 → rsp err = 0, rdata = 32'hDEAD_BEEF. Read rsp_valid occurs exactly 2 cycles after its handshake.
- Byte mask: preload 0x20 = 32'h1122_3344, write wdata 32'hAAAA_AAAA with wmask 4'b0101, then read → 32'h11AA_33AA.
- Errors:
  - Read at 0x22 → err = 1, rdata = 0, no sram_en pulse.
  - Read at base + 4*itcm_depth → err = 1.
  - The following read at 0x0 returns correct data in order.
- Backpressure: hold rsp_ready = 0 and issue 6 reads → exactly 4 accepted, cmd_ready = 0. Release rsp_ready → 4 responses in order, then the remaining 2 are accepted.
- Throughput: 64 back-to-back reads of incrementing addresses with rsp_ready = 1 → cmd_ready never drops, 64 ordered responses in 66 cycles.
- Reset mid-stream: assert rst with 3 responses outstanding → next cycle rsp_valid = 0, cmd_ready = 0. After release a fresh read returns correct data and no stale response appears.
